// File: rtl/twiddle_coeff_stream.sv
// Runtime-writable W_N^k table that streams one FFT stage's butterfly twiddles,
// LANES per beat, over valid/ready with optional saturating conjugation.
module twiddle_coeff_stream #(
   parameter int NBITS = 5,
   parameter int N     = 8,
   parameter int LANES = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  logic [$clog2(N)-2:0]             wr_addr,
   input  logic [2*NBITS-1:0]               wr_data,
   input  logic                             start,
   input  logic [$clog2($clog2(N))-1:0]     stage,
   input  logic                             inverse,
   input  logic                             abort,
   output logic                             c_valid,
   input  logic                             c_ready,
   output logic [LANES*2*NBITS-1:0]         c_data,
   output logic                             c_last,
   output logic                             busy,
   output logic                             err
);

   localparam int LOG2N = $clog2(N);
   localparam int KW    = LOG2N - 1;
   localparam int SGW   = $clog2(LOG2N);
   localparam int EW    = 2 * NBITS;
   localparam int BEATS = N / (2 * LANES);
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic signed [NBITS-1:0] IM_MIN = {1'b1, {(NBITS-1){1'b0}}};
   localparam logic signed [NBITS-1:0] IM_MAX = {1'b0, {(NBITS-1){1'b1}}};

   // PREP is the one-cycle table read that puts beat 0 on the output register
   typedef enum logic [1:0] {IDLE, PREP, STREAM} state_t;

   state_t              state, state_nxt;
   logic [EW-1:0]       tbl [N/2];
   logic [SGW-1:0]      stage_q;
   logic                inverse_q;
   logic [CW-1:0]       beat_p0, beat_nxt;
   logic                load, err_nxt, start_ok, hs;
   logic                vld_p1, last_p1, busy_p1, err_p1;
   logic [LANES*EW-1:0] data_p1, beat_data;
   logic [EW-1:0]       entry;

   function automatic logic [KW-1:0] tw_index(input logic [KW-1:0] b, input logic [SGW-1:0] s);
      logic [KW-1:0] mask;
      mask = KW'((1 << s) - 1);
      return (b & mask) << (KW - int'(s));
   endfunction

   function automatic logic [KW-1:0] lane_b(input logic [CW-1:0] j, input int i);
      return KW'(int'(j) * LANES + i);
   endfunction

   // Negating the most negative Im would wrap, so it clips to the largest positive value
   function automatic logic [EW-1:0] conj_sat(input logic [EW-1:0] e);
      logic signed [NBITS-1:0] im;
      im = $signed(e[NBITS-1:0]);
      if (im == IM_MIN) return {e[EW-1:NBITS], IM_MAX};
      return {e[EW-1:NBITS], -im};
   endfunction

   assign start_ok = start && (state == IDLE) && ({1'b0, stage} < (SGW+1)'(LOG2N));
   assign hs       = vld_p1 && c_ready;

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_p0;
      load      = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (start_ok) begin
                  state_nxt = PREP;
                  beat_nxt  = '0;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         PREP: begin
            state_nxt = STREAM;
            load      = 1'b1;
         end
         STREAM: begin
            if (hs) begin
               if (last_p1) begin
                  state_nxt = IDLE;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_p0 + CW'(1);
                  load     = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE) begin
         if (start || wr_en) err_nxt = 1'b1;
         if (abort) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            load      = 1'b0;
         end
      end
   end

   always_comb begin
      beat_data = '0;
      entry     = '0;
      for (int i = 0; i < LANES; i++) begin
         entry = tbl[tw_index(lane_b(beat_nxt, i), stage_q)];
         beat_data[i*EW +: EW] = inverse_q ? conj_sat(entry) : entry;
      end
   end

   // Table contents and the sampled stage settings survive rst_n
   always_ff @(posedge clk) begin
      if (wr_en && (state == IDLE)) tbl[wr_addr] <= wr_data;
      if (start_ok) begin
         stage_q   <= stage;
         inverse_q <= inverse;
      end
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         beat_p0 <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         data_p1 <= '0;
         busy_p1 <= 1'b0;
         err_p1  <= 1'b0;
      end else begin
         state   <= state_nxt;
         beat_p0 <= beat_nxt;
         vld_p1  <= (state_nxt == STREAM);
         busy_p1 <= (state_nxt != IDLE);
         err_p1  <= err_nxt;
         if (load) begin
            data_p1 <= beat_data;
            last_p1 <= (beat_nxt == LAST_BEAT);
         end else if (state_nxt != STREAM) begin
            last_p1 <= 1'b0;
         end
      end
   end

   assign c_valid = vld_p1;
   assign c_data  = data_p1;
   assign c_last  = last_p1;
   assign busy    = busy_p1;
   assign err     = err_p1;

endmodule
